fir_out_capture: RTL and testbench

Output-side capture buffer for the 64-tap FIR. Consumes the filter's output sample strobe and 16-bit result on `clk2`, stores a programmable-length frame of results in a 64-entry ring buffer, and presents them to a host through a registered read port. It is the reader/sink for the `valid_out`/`dout` stream produced by the FIR core, with occupancy, overflow and frame-done status.

---
 rtl/fir_pkg.sv | 12 +
 rtl/fir_out_capture_if.sv | 29 ++
 rtl/omem.sv | 32 +++
 rtl/fir_out_capture.sv | 114 +++++++++++
 tb/tb_fir_out_capture.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared constants and capture FSM state type for the FIR output capture path.
package fir_pkg;
  localparam int DW    = 16;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } cap_state_e;
endpackage

// File: rtl/fir_out_capture_if.sv
// Sample stream, frame control and host read/status signals of the capture buffer.
interface fir_out_capture_if;
  import fir_pkg::*;

  logic                 valid_in;
  logic signed [DW-1:0] din;
  logic                 start;
  logic [AW:0]          frame_len;
  logic                 rd_en;
  logic signed [DW-1:0] rd_data;
  logic                 rd_valid;
  logic [AW:0]          count;
  logic                 full;
  logic                 empty;
  logic                 overflow;
  logic                 clr_ovf;
  logic                 frame_done;
  logic                 busy;

  modport slave (
    input  valid_in, din, start, frame_len, rd_en, clr_ovf,
    output rd_data, rd_valid, count, full, empty, overflow, frame_done, busy
  );

  modport master (
    output valid_in, din, start, frame_len, rd_en, clr_ovf,
    input  rd_data, rd_valid, count, full, empty, overflow, frame_done, busy
  );
endinterface

// File: rtl/omem.sv
// DEPTH x DW simple dual-port RAM: synchronous write, registered read port.
module omem #(
  parameter int DW    = 16,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic signed [DW-1:0] wdata,
  input  logic                 re,
  input  logic [AW-1:0]        raddr,
  output logic signed [DW-1:0] rdata
);
  logic signed [DW-1:0] mem [DEPTH];
  logic signed [DW-1:0] rdata_q, rdata_d;

  // Same-address read/write returns the old word (read-before-write).
  always_comb rdata_d = re ? mem[raddr] : rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rstn) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/fir_out_capture.sv
// Frame capture of FIR output samples into a ring buffer with a registered host read port.
module fir_out_capture
  import fir_pkg::*;
(
  input logic               clk2,
  input logic               rstn,
  fir_out_capture_if.slave  bus
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  cap_state_e  state_q, state_d;
  logic [AW:0] len_q, len_d, fcnt_q, fcnt_d, count_q, count_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic rd_valid_q, rd_valid_d, full_q, full_d, empty_q, empty_d;
  logic ovf_q, ovf_d, fdone_q, fdone_d, busy_q, busy_d;
  logic capture, arm, rd_ok, wr_ok, drop;

  assign capture = (state_q == ST_CAPTURE);
  assign arm     = bus.start && (bus.frame_len != '0);
  assign rd_ok   = bus.rd_en && (count_q != '0);
  // A full buffer still accepts a strobe when a read frees a slot the same cycle.
  assign wr_ok   = capture && bus.valid_in && ((count_q != FULL_CNT) || rd_ok);
  assign drop    = capture && bus.valid_in && !wr_ok;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    fcnt_d  = fcnt_q;
    fdone_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm) begin
          state_d = ST_CAPTURE;
          len_d   = bus.frame_len;
          fcnt_d  = '0;
        end
      end
      ST_CAPTURE: begin
        // Dropped samples still advance the frame.
        if (bus.valid_in) begin
          if (fcnt_q == len_q - 1'b1) begin
            state_d = ST_DONE;
            fdone_d = 1'b1;
          end else begin
            fcnt_d = fcnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wptr_d  = wr_ok ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = rd_ok ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q;
    if (wr_ok && !rd_ok)      count_d = count_q + 1'b1;
    else if (rd_ok && !wr_ok) count_d = count_q - 1'b1;
    full_d     = (count_d == FULL_CNT);
    empty_d    = (count_d == '0);
    busy_d     = (state_d == ST_CAPTURE);
    rd_valid_d = rd_ok;
    ovf_d      = drop ? 1'b1 : (bus.clr_ovf ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk2) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      fcnt_q     <= '0;
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      rd_valid_q <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      ovf_q      <= 1'b0;
      fdone_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      fcnt_q     <= fcnt_d;
      count_q    <= count_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      rd_valid_q <= rd_valid_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      ovf_q      <= ovf_d;
      fdone_q    <= fdone_d;
      busy_q     <= busy_d;
    end
  end

  omem #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_omem (
    .clk   (clk2),
    .rstn  (rstn),
    .we    (wr_ok),
    .waddr (wptr_q),
    .wdata (bus.din),
    .re    (rd_ok),
    .raddr (rptr_q),
    .rdata (bus.rd_data)
  );

  assign bus.rd_valid   = rd_valid_q;
  assign bus.count      = count_q;
  assign bus.full       = full_q;
  assign bus.empty      = empty_q;
  assign bus.overflow   = ovf_q;
  assign bus.frame_done = fdone_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_fir_out_capture.sv
// Directed/random bench for fir_out_capture against a queue-based frame model.
module tb_fir_out_capture;
  logic clk2 = 1'b0;
  logic rstn;
  int compared = 0;
  int mismatched = 0;

  fir_out_capture_if bus();

  fir_out_capture dut (
    .clk2 (clk2),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk2 = ~clk2;

  // Reference model: FIFO of words, frame-remaining counter, sticky overflow.
  logic [15:0] mq[$];
  bit          m_cap;
  int          m_rem;
  bit          m_ovf, m_done, m_rdv;
  logic [15:0] m_rdata;

  task automatic model_reset();
    mq.delete();
    m_cap = 0; m_rem = 0; m_ovf = 0; m_done = 0; m_rdv = 0; m_rdata = '0;
  endtask

  task automatic model_update(input logic v, input logic [15:0] d, input logic s,
                              input logic [6:0] fl, input logic r, input logic c);
    bit rd, dropped;
    rd = r && (mq.size() > 0);
    dropped = 0;
    m_rdv = rd;
    if (rd) m_rdata = mq.pop_front();
    m_done = 0;
    if (m_cap && v) begin
      if (mq.size() < 64) mq.push_back(d);
      else begin dropped = 1; m_ovf = 1; end
      m_rem = m_rem - 1;
      if (m_rem == 0) begin m_cap = 0; m_done = 1; end
    end else if (!m_cap && s && fl != 0) begin
      m_cap = 1;
      m_rem = int'(fl);
    end
    if (!dropped && c) m_ovf = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("rd_valid",   32'(bus.rd_valid),          32'(m_rdv));
    chk("rd_data",    32'($unsigned(bus.rd_data)), 32'(m_rdata));
    chk("count",      32'(bus.count),             32'(mq.size()));
    chk("full",       32'(bus.full),              32'(mq.size() == 64));
    chk("empty",      32'(bus.empty),             32'(mq.size() == 0));
    chk("overflow",   32'(bus.overflow),          32'(m_ovf));
    chk("frame_done", 32'(bus.frame_done),        32'(m_done));
    chk("busy",       32'(bus.busy),              32'(m_cap));
  endtask

  task automatic step(input logic rn, input logic v, input logic [15:0] d, input logic s,
                      input logic [6:0] fl, input logic r, input logic c);
    rstn = rn;
    bus.valid_in = v; bus.din = d; bus.start = s; bus.frame_len = fl;
    bus.rd_en = r; bus.clr_ovf = c;
    @(posedge clk2); #1;
    if (!rn) model_reset();
    else model_update(v, d, s, fl, r, c);
    check_all();
  endtask

  initial begin
    rstn = 1'b0;
    bus.valid_in = 0; bus.din = '0; bus.start = 0; bus.frame_len = '0;
    bus.rd_en = 0; bus.clr_ovf = 0;
    model_reset();

    // Reset state
    step(0, 0, 16'h0, 0, 7'd0, 0, 0);
    step(0, 0, 16'h0, 0, 7'd0, 0, 0);

    // Frame of 4: strobes 1..4, then read back
    step(1, 0, 16'h0, 1, 7'd4, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 16'(i + 1), 0, 7'd0, 0, 0);
    step(1, 0, 16'h0, 0, 7'd0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 16'h0, 0, 7'd0, 1, 0);
    step(1, 0, 16'h0, 0, 7'd0, 0, 0);
    chk("after_drain_empty", 32'(bus.empty), 32'd1);

    // Frame of 64 plus two extra strobes after DONE
    step(1, 0, 16'h0, 1, 7'd64, 0, 0);
    for (int i = 0; i < 64; i++) step(1, 1, 16'($urandom), 0, 7'd0, 0, 0);
    step(1, 1, 16'($urandom), 0, 7'd0, 0, 0);
    step(1, 1, 16'($urandom), 0, 7'd0, 0, 0);
    chk("len64_count", 32'(bus.count), 32'd64);

    // Buffer full, frame of 66: two drops, clear, then clear racing a new drop
    step(1, 0, 16'h0, 1, 7'd66, 0, 0);
    step(1, 1, 16'h1111, 0, 7'd0, 0, 0);
    step(1, 1, 16'h2222, 0, 7'd0, 0, 0);
    chk("ovf_set", 32'(bus.overflow), 32'd1);
    step(1, 0, 16'h0, 0, 7'd0, 0, 1);
    step(1, 1, 16'h3333, 0, 7'd0, 0, 1);
    step(1, 0, 16'h0, 0, 7'd0, 0, 1);

    // Full buffer, simultaneous write 0x8000 and read
    step(1, 1, 16'h8000, 0, 7'd0, 1, 0);
    for (int i = 0; i < 66; i++) step(1, 0, 16'h0, 0, 7'd0, 1'($urandom_range(0, 3) != 0), 0);
    while (mq.size() > 0) step(1, 0, 16'h0, 0, 7'd0, 1, 0);
    chk("last_read_8000", 32'($unsigned(bus.rd_data)), 32'h8000);

    // Empty buffer, simultaneous write and read
    step(1, 1, 16'hABCD, 0, 7'd0, 1, 0);

    // Random traffic until the 66-sample frame finishes
    for (int i = 0; i < 150; i++)
      step(1, 1'($urandom_range(0, 1)), 16'($urandom), 0, 7'd0,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
    while (mq.size() > 0) step(1, 0, 16'h0, 0, 7'd0, 1, 0);

    // Reset mid-frame at count 10
    step(1, 0, 16'h0, 1, 7'd20, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 1, 16'($urandom), 0, 7'd0, 0, 0);
    chk("pre_reset_count", 32'(bus.count), 32'd10);
    step(0, 1, 16'h5555, 0, 7'd0, 1, 0);
    step(1, 0, 16'h0, 1, 7'd0, 0, 0);
    step(1, 1, 16'h7777, 0, 7'd0, 0, 0);
    chk("len0_ignored_busy", 32'(bus.busy), 32'd0);

    // Short random frame after reset
    step(1, 0, 16'h0, 1, 7'd3, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 16'($urandom), 0, 7'd0, 1'($urandom_range(0, 1)), 0);
    for (int i = 0; i < 4; i++) step(1, 0, 16'h0, 0, 7'd0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
